// File: rtl/cpu_params.sv
// Shared frontend/decode types: the fetch block packet and the per-lane decode bundle.
package cpu_params;

   localparam int IF_WIDTH = 4;
   localparam int ID_WIDTH = 2;
   localparam int SLOT_W   = (IF_WIDTH > 1) ? $clog2(IF_WIDTH) : 1;

   typedef struct packed {
      logic [IF_WIDTH-1:0][31:0] inst;
      logic [31:0]               pc;
      logic [IF_WIDTH-1:0]       predict_taken;
      logic [IF_WIDTH-1:0][31:0] predict_target;
      logic [IF_WIDTH-1:0]       valid;
   } fetch_pkt_t;

   typedef struct packed {
      logic [ID_WIDTH-1:0]       slot_valid;
      logic [ID_WIDTH-1:0][31:0] inst;
      logic [ID_WIDTH-1:0][31:0] pc;
      logic [ID_WIDTH-1:0]       predict_taken;
      logic [ID_WIDTH-1:0][31:0] predict_target;
   } dec_bundle_t;

   // Instructions are 4 bytes, so a slot's PC is the block PC plus 4 x slot index.
   function automatic logic [31:0] slot_pc(input logic [31:0] base, input logic [SLOT_W-1:0] slot);
      return base + 32'({slot, 2'b00});
   endfunction

endpackage

// File: rtl/frontend_fifo_itf.sv
// Valid/ready channel carrying one fetch block from fetch into the fetch queue.
interface frontend_fifo_itf;
   import cpu_params::*;

   logic       valid;
   logic       ready;
   fetch_pkt_t packet;

   modport fifo  (input valid, input packet, output ready);
   modport fetch (output valid, output packet, input ready);
endinterface

// File: rtl/fetch_slot_select.sv
// Picks the first ID_WIDTH set bits of a pending-slot mask, in ascending slot order.
module fetch_slot_select #(
   parameter int IF_WIDTH = 4,
   parameter int ID_WIDTH = 2
) (
   input  logic [IF_WIDTH-1:0]                pending,
   output logic [ID_WIDTH-1:0][((IF_WIDTH > 1) ? $clog2(IF_WIDTH) : 1)-1:0] lane_slot,
   output logic [ID_WIDTH-1:0]                lane_valid,
   output logic [IF_WIDTH-1:0]                emit_mask
);
   localparam int SW = (IF_WIDTH > 1) ? $clog2(IF_WIDTH) : 1;
   localparam int CW = $clog2(IF_WIDTH + 1);

   logic [CW-1:0] seen;

   // NOTE: 'seen' is a running count within one evaluation, so it is assigned
   // with blocking '=' and given a default before the loop to avoid a latch.
   always_comb begin
      lane_slot  = '0;
      lane_valid = '0;
      emit_mask  = '0;
      seen       = '0;
      for (int s = 0; s < IF_WIDTH; s++) begin
         if (pending[s]) begin
            for (int l = 0; l < ID_WIDTH; l++) begin
               if (seen == CW'(l)) begin
                  lane_slot[l]  = SW'(s);
                  lane_valid[l] = 1'b1;
                  emit_mask[s]  = 1'b1;
               end
            end
            seen = seen + CW'(1);
         end
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Circular buffer of fetch blocks feeding decode up to ID_WIDTH instructions per cycle.
module fetch_queue #(
   parameter int DEPTH    = 8,
   parameter int IF_WIDTH = cpu_params::IF_WIDTH,
   parameter int ID_WIDTH = cpu_params::ID_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      backend_flush,
   frontend_fifo_itf.fifo            from_fetch,
   output logic                      dec_valid,
   input  logic                      dec_ready,
   output logic [ID_WIDTH-1:0]       dec_slot_valid,
   output logic [ID_WIDTH-1:0][31:0] dec_inst,
   output logic [ID_WIDTH-1:0][31:0] dec_pc,
   output logic [ID_WIDTH-1:0]       dec_predict_taken,
   output logic [ID_WIDTH-1:0][31:0] dec_predict_target
);
   import cpu_params::*;

   localparam int PW = $clog2(DEPTH);
   localparam int SW = (IF_WIDTH > 1) ? $clog2(IF_WIDTH) : 1;

   fetch_pkt_t                  entries [DEPTH];
   fetch_pkt_t                  head;
   logic [PW-1:0]               rd_ptr, wr_ptr;
   logic [PW:0]                 count;
   logic [IF_WIDTH-1:0]         consumed, pending, emit_mask;
   logic [ID_WIDTH-1:0][SW-1:0] lane_slot;
   logic [ID_WIDTH-1:0]         lane_valid;
   logic                        push, pop, retire;
   dec_bundle_t                 bundle;

   assign head    = entries[rd_ptr];
   assign pending = head.valid & ~consumed;

   // Ready looks only at registered occupancy; a pop in the same cycle does not free a slot early.
   assign from_fetch.ready = rst && (count != (PW+1)'(DEPTH)) && !backend_flush;
   assign dec_valid        = (count != '0) && !backend_flush;

   assign push   = from_fetch.valid && from_fetch.ready && (|from_fetch.packet.valid);
   assign pop    = dec_valid && dec_ready;
   assign retire = pop && ((pending & ~emit_mask) == '0);

   fetch_slot_select #(
      .IF_WIDTH (IF_WIDTH),
      .ID_WIDTH (ID_WIDTH)
   ) u_select (
      .pending    (pending),
      .lane_slot  (lane_slot),
      .lane_valid (lane_valid),
      .emit_mask  (emit_mask)
   );

   always_comb begin
      bundle            = '0;
      bundle.slot_valid = lane_valid;
      for (int l = 0; l < ID_WIDTH; l++) begin
         bundle.inst[l]           = head.inst[lane_slot[l]];
         bundle.pc[l]             = slot_pc(head.pc, lane_slot[l]);
         bundle.predict_taken[l]  = head.predict_taken[lane_slot[l]];
         bundle.predict_target[l] = head.predict_target[lane_slot[l]];
      end
   end

   assign dec_slot_valid     = bundle.slot_valid;
   assign dec_inst           = bundle.inst;
   assign dec_pc             = bundle.pc;
   assign dec_predict_taken  = bundle.predict_taken;
   assign dec_predict_target = bundle.predict_target;

   // NOTE: all state below is registered with non-blocking '<=' so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         consumed <= '0;
      end else if (backend_flush) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         consumed <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (retire) begin
            rd_ptr   <= rd_ptr + 1'b1;
            consumed <= '0;
         end else if (pop) begin
            consumed <= consumed | emit_mask;
         end
         case ({push, retire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // NOTE: the packet array has no reset; occupancy is tracked by count, so
   // stale entries are never visible and the array stays plain flops without a reset net.
   always_ff @(posedge clk) begin
      if (push) entries[wr_ptr] <= from_fetch.packet;
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a per-instruction queue model.
module tb_fetch_queue;
   import cpu_params::*;

   localparam int DEPTH = 4;
   localparam int IFW   = IF_WIDTH;
   localparam int IDW   = ID_WIDTH;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 backend_flush = 1'b0;
   logic                 dec_ready = 1'b0;
   logic                 dec_valid;
   logic [IDW-1:0]       dec_slot_valid;
   logic [IDW-1:0][31:0] dec_inst;
   logic [IDW-1:0][31:0] dec_pc;
   logic [IDW-1:0]       dec_predict_taken;
   logic [IDW-1:0][31:0] dec_predict_target;

   frontend_fifo_itf ff ();

   fetch_queue #(.DEPTH(DEPTH), .IF_WIDTH(IFW), .ID_WIDTH(IDW)) dut (
      .clk                (clk),
      .rst                (rst),
      .backend_flush      (backend_flush),
      .from_fetch         (ff),
      .dec_valid          (dec_valid),
      .dec_ready          (dec_ready),
      .dec_slot_valid     (dec_slot_valid),
      .dec_inst           (dec_inst),
      .dec_pc             (dec_pc),
      .dec_predict_taken  (dec_predict_taken),
      .dec_predict_target (dec_predict_target)
   );

   always #5 clk = ~clk;

   // Model: flat queue of not-yet-emitted instructions, tagged by the block they came from.
   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] target;
      logic        taken;
      int          blk;
   } rec_t;

   rec_t mq[$];
   int   blk_count = 0;
   int   next_blk  = 0;
   int   popped    = 0;
   int   n_cmp     = 0;
   int   n_err     = 0;
   bit   took      = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic fetch_pkt_t make_pkt(input logic [31:0] pc, input logic [IFW-1:0] mask);
      fetch_pkt_t p;
      p.pc    = pc;
      p.valid = mask;
      for (int s = 0; s < IFW; s++) begin
         p.inst[s]           = $urandom;
         p.predict_taken[s]  = 1'($urandom);
         p.predict_target[s] = $urandom;
      end
      return p;
   endfunction

   task automatic drive(input logic v, input fetch_pkt_t p, input logic rdy, input logic fl);
      ff.valid      = v;
      ff.packet     = p;
      dec_ready     = rdy;
      backend_flush = fl;
      #1;
   endtask

   // Compare outputs against the model, then advance the model across one rising edge.
   task automatic tick();
      logic exp_dv, exp_rdy;
      int   k, b;
      rec_t r;
      exp_dv  = (mq.size() != 0) && !backend_flush;
      exp_rdy = (blk_count != DEPTH) && !backend_flush;
      check("ready", 32'(ff.ready), 32'(exp_rdy));
      check("dec_valid", 32'(dec_valid), 32'(exp_dv));
      k = 0;
      if (exp_dv) begin
         for (int l = 0; l < IDW; l++)
            if (l < mq.size() && mq[l].blk == mq[0].blk) k++;
         check("slot_valid", 32'(dec_slot_valid), 32'((1 << k) - 1));
         for (int l = 0; l < k; l++) begin
            check("lane_pc", dec_pc[l], mq[l].pc);
            check("lane_inst", dec_inst[l], mq[l].inst);
            check("lane_target", dec_predict_target[l], mq[l].target);
            check("lane_taken", 32'(dec_predict_taken[l]), 32'(mq[l].taken));
         end
      end
      @(posedge clk);
      took = 1'b0;
      if (backend_flush) begin
         mq.delete();
         blk_count = 0;
      end else begin
         if (exp_dv && dec_ready) begin
            b = mq[0].blk;
            repeat (k) begin
               void'(mq.pop_front());
               popped++;
            end
            if (mq.size() == 0 || mq[0].blk != b) blk_count--;
         end
         if (ff.valid && exp_rdy) begin
            took = 1'b1;
            if (|ff.packet.valid) begin
               for (int s = 0; s < IFW; s++) begin
                  if (ff.packet.valid[s]) begin
                     r.inst   = ff.packet.inst[s];
                     r.pc     = ff.packet.pc + 32'(4 * s);
                     r.target = ff.packet.predict_target[s];
                     r.taken  = ff.packet.predict_taken[s];
                     r.blk    = next_blk;
                     mq.push_back(r);
                  end
               end
               next_blk++;
               blk_count++;
            end
         end
      end
      @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, time %0t limit 1000000", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      fetch_pkt_t p, idle;
      fetch_pkt_t fblk[5];
      fetch_pkt_t wblk[10];
      int acc, p0;

      idle = '0;
      drive(1'b0, idle, 1'b0, 1'b0);
      check("reset_ready", 32'(ff.ready), 32'd0);
      check("reset_dec_valid", 32'(dec_valid), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Single aligned block
      p = make_pkt(32'h1eceb000, 4'b1111);
      drive(1'b1, p, 1'b1, 1'b0);
      check("no_bypass", 32'(dec_valid), 32'd0);
      tick();
      drive(1'b0, p, 1'b1, 1'b0);
      check("blk0_c1_pc0", dec_pc[0], 32'h1eceb000);
      check("blk0_c1_pc1", dec_pc[1], 32'h1eceb004);
      tick();
      drive(1'b0, p, 1'b1, 1'b0);
      check("blk0_c2_pc0", dec_pc[0], 32'h1eceb008);
      check("blk0_c2_pc1", dec_pc[1], 32'h1eceb00c);
      tick();
      drive(1'b0, p, 1'b1, 1'b0);
      check("blk0_c3_empty", 32'(dec_valid), 32'd0);
      tick();

      // Block with slot 0 invalid
      p = make_pkt(32'h1eceb010, 4'b1110);
      drive(1'b1, p, 1'b1, 1'b0);
      tick();
      drive(1'b0, p, 1'b1, 1'b0);
      check("mis_b1_pc0", dec_pc[0], 32'h1eceb014);
      check("mis_b1_pc1", dec_pc[1], 32'h1eceb018);
      tick();
      drive(1'b0, p, 1'b1, 1'b0);
      check("mis_b2_pc0", dec_pc[0], 32'h1eceb01c);
      check("mis_b2_sv", 32'(dec_slot_valid), 32'b01);
      tick();
      drive(1'b0, p, 1'b1, 1'b0);
      tick();

      // Fill under backpressure, then drain
      for (int i = 0; i < 5; i++) fblk[i] = make_pkt(32'h30000000 + 32'(16 * i), 4'b1111);
      acc = 0;
      for (int c = 0; c < 8; c++) begin
         drive(acc < 5, fblk[acc < 5 ? acc : 4], 1'b0, 1'b0);
         tick();
         if (took) acc++;
      end
      check("full_accepted", 32'(acc), 32'd4);
      drive(1'b1, fblk[4], 1'b0, 1'b0);
      check("full_ready_low", 32'(ff.ready), 32'd0);
      tick();
      p0 = popped;
      for (int c = 0; c < 20 && mq.size() != 0; c++) begin
         drive(1'b0, idle, 1'b1, 1'b0);
         tick();
      end
      check("full_drained", 32'(popped - p0), 32'd16);

      // Wrap-around stream with toggling decode ready
      for (int i = 0; i < 10; i++) wblk[i] = make_pkt(32'h20000000 + 32'(16 * i), 4'b1111);
      acc = 0;
      p0  = popped;
      for (int c = 0; c < 200 && (acc < 10 || mq.size() != 0); c++) begin
         drive(acc < 10, wblk[acc < 10 ? acc : 9], 1'(c), 1'b0);
         tick();
         if (took) acc++;
      end
      check("wrap_count", 32'(popped - p0), 32'd40);

      // Flush with the head block half consumed
      drive(1'b1, make_pkt(32'h40000000, 4'b1111), 1'b0, 1'b0);
      tick();
      drive(1'b1, make_pkt(32'h40000010, 4'b1111), 1'b1, 1'b0);
      tick();
      drive(1'b1, make_pkt(32'h40000020, 4'b1111), 1'b1, 1'b1);
      check("flush_ready_low", 32'(ff.ready), 32'd0);
      tick();
      p = make_pkt(32'h50000000, 4'b1111);
      drive(1'b1, p, 1'b1, 1'b0);
      check("flush_count", 32'(dut.count), 32'd0);
      check("flush_dec_valid", 32'(dec_valid), 32'd0);
      tick();
      drive(1'b0, idle, 1'b1, 1'b0);
      check("flush_new_first", dec_pc[0], 32'h50000000);
      tick();
      drive(1'b0, idle, 1'b1, 1'b0);
      tick();

      // Random traffic, including empty masks and occasional flushes
      for (int c = 0; c < 400; c++) begin
         p = make_pkt($urandom & 32'hfffffff0, 4'($urandom));
         drive($urandom_range(0, 3) != 0, p, $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
         tick();
      end

      // Asynchronous reset between clock edges with blocks queued
      drive(1'b1, make_pkt(32'h60000000, 4'b1111), 1'b0, 1'b0);
      tick();
      drive(1'b1, make_pkt(32'h60000010, 4'b1111), 1'b0, 1'b0);
      tick();
      drive(1'b0, idle, 1'b0, 1'b0);
      check("pre_reset_valid", 32'(dec_valid), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_dec_valid", 32'(dec_valid), 32'd0);
      check("async_rst_ready", 32'(ff.ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      mq.delete();
      blk_count = 0;
      drive(1'b1, make_pkt(32'h70000000, 4'b0011), 1'b1, 1'b0);
      check("post_rst_empty", 32'(dec_valid), 32'd0);
      tick();
      drive(1'b0, idle, 1'b1, 1'b0);
      check("post_rst_pc", dec_pc[0], 32'h70000000);
      tick();
      drive(1'b0, idle, 1'b1, 1'b0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
